// File: rtl/gyro_pkg.sv
// Shared types and helpers for the gyro rate integrator.
package gyro_pkg;

    typedef enum logic {
        RUN = 1'b0,
        CAL = 1'b1
    } gyro_state_t;

    localparam int CH_X = 0;  // roll
    localparam int CH_Y = 1;  // pitch
    localparam int CH_Z = 2;  // yaw

    // Widest value the clamp helper accepts; callers sign-extend into it.
    localparam int SAT_W = 128;

    // Clamp a signed value to the range of an ow-bit signed number.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                    input int unsigned              ow);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (ow - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/gyro_chan_acc.sv
// One channel: window accumulator, bias calibration, snapshot and scale/saturate stage.
module gyro_chan_acc
    import gyro_pkg::*;
#(
    parameter int IN_W        = 16,
    parameter int ACC_W       = 40,
    parameter int OUT_W       = 32,
    parameter int SCALE_MUL   = 7,
    parameter int SCALE_SHIFT = 8,
    parameter int CAL_LOG2    = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  i_sample,
    input  logic                    i_acc_en,
    input  logic                    i_acc_clr,
    input  logic                    i_win_end,
    input  logic                    i_cal_en,
    input  logic                    i_cal_clr,
    input  logic                    i_cal_end,
    input  logic                    i_snap_ld,
    input  logic                    i_res_ld,
    output logic signed [OUT_W-1:0] o_result,
    output logic signed [IN_W-1:0]  o_bias
);

    localparam int PROD_W = ACC_W + 32;
    localparam int CAL_W  = IN_W + CAL_LOG2;
    localparam logic signed [PROD_W-1:0] MUL_S = PROD_W'(SCALE_MUL);

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_snap;
    logic signed [ACC_W-1:0]  r_snap_q;
    logic signed [CAL_W-1:0]  r_cal_acc;
    logic signed [IN_W-1:0]   r_bias;
    logic signed [OUT_W-1:0]  r_result;

    logic signed [IN_W:0]     w_delta;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic signed [CAL_W-1:0]  w_cal_nxt;
    logic signed [PROD_W-1:0] w_prod;

    // Difference taken one bit wider so full-scale sample minus full-scale bias cannot wrap.
    assign w_delta   = {i_sample[IN_W-1], i_sample} - {r_bias[IN_W-1], r_bias};
    assign w_acc_nxt = r_acc + ACC_W'(w_delta);
    assign w_cal_nxt = r_cal_acc + CAL_W'(i_sample);
    assign w_prod    = PROD_W'(r_snap_q) * MUL_S;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_snap <= '0;
        end else if (i_acc_clr) begin
            r_acc <= '0;
        end else if (i_win_end) begin
            // Closing sample lands in the snapshot; next window starts empty.
            r_snap <= w_acc_nxt;
            r_acc  <= '0;
        end else if (i_acc_en) begin
            r_acc <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cal_acc <= '0;
            r_bias    <= '0;
        end else if (i_cal_clr) begin
            r_cal_acc <= '0;
        end else if (i_cal_end) begin
            r_bias    <= IN_W'(w_cal_nxt >>> CAL_LOG2);
            r_cal_acc <= '0;
        end else if (i_cal_en) begin
            r_cal_acc <= w_cal_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_q <= '0;
            r_result <= '0;
        end else begin
            if (i_snap_ld)
                r_snap_q <= r_snap;
            if (i_res_ld)
                r_result <= OUT_W'(sat(SAT_W'(w_prod >>> SCALE_SHIFT), OUT_W));
        end
    end

    assign o_result = r_result;
    assign o_bias   = r_bias;

endmodule

// File: rtl/gyro_integrator.sv
// Multi-channel gyro rate integrator: window control FSM plus one accumulator slice per channel.
module gyro_integrator
    import gyro_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int IN_W        = 16,
    parameter int WINDOW      = 10000,
    parameter int ACC_W       = 40,
    parameter int OUT_W       = 32,
    parameter int SCALE_MUL   = 7,
    parameter int SCALE_SHIFT = 8,
    parameter int CAL_LOG2    = 10
) (
    input  logic                   clk_100mhz,
    input  logic                   rst_in,
    input  logic                   sample_valid,
    input  logic [N_CH*IN_W-1:0]   sample,
    input  logic                   clear,
    input  logic                   cal_start,
    output logic [N_CH*OUT_W-1:0]  result,
    output logic                   result_valid,
    output logic [N_CH*IN_W-1:0]   bias,
    output logic                   cal_busy,
    output logic                   cal_done
);

    localparam int CNT_W  = $clog2(WINDOW);
    localparam int STAGES = 2;

    if (WINDOW < 2) begin : g_chk_window
        $error("WINDOW must be at least 2");
    end
    if (ACC_W < IN_W + 2 + $clog2(WINDOW)) begin : g_chk_acc
        $error("ACC_W too narrow for WINDOW samples of IN_W bits");
    end
    if (ACC_W + 32 > SAT_W) begin : g_chk_prod
        $error("scaled product wider than the saturation helper");
    end
    if (CAL_LOG2 < 1) begin : g_chk_cal
        $error("CAL_LOG2 must be at least 1");
    end

    gyro_state_t          r_state;
    gyro_state_t          w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CAL_LOG2-1:0]  r_cal_cnt;
    logic [CAL_LOG2-1:0]  w_cal_cnt_nxt;
    logic [STAGES:0]      r_vld_pipe;
    logic                 r_cal_done;

    logic                 w_acc_en;
    logic                 w_acc_clr;
    logic                 w_win_end;
    logic                 w_cal_en;
    logic                 w_cal_clr;
    logic                 w_cal_end;

    // cal_start outranks clear; either one swallows a same-cycle sample.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cal_cnt_nxt = r_cal_cnt;
        w_acc_en      = 1'b0;
        w_acc_clr     = 1'b0;
        w_win_end     = 1'b0;
        w_cal_en      = 1'b0;
        w_cal_clr     = 1'b0;
        w_cal_end     = 1'b0;
        if (cal_start) begin
            w_state_nxt   = CAL;
            w_acc_clr     = 1'b1;
            w_cal_clr     = 1'b1;
            w_cnt_nxt     = '0;
            w_cal_cnt_nxt = '0;
        end else if (clear) begin
            w_state_nxt   = RUN;
            w_acc_clr     = 1'b1;
            w_cal_clr     = 1'b1;
            w_cnt_nxt     = '0;
            w_cal_cnt_nxt = '0;
        end else if (sample_valid) begin
            case (r_state)
                RUN: begin
                    w_acc_en = 1'b1;
                    if (r_cnt == CNT_W'(WINDOW - 1)) begin
                        w_win_end = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                CAL: begin
                    w_cal_en = 1'b1;
                    if (&r_cal_cnt) begin
                        w_cal_end     = 1'b1;
                        w_state_nxt   = RUN;
                        w_acc_clr     = 1'b1;
                        w_cnt_nxt     = '0;
                        w_cal_cnt_nxt = '0;
                    end else begin
                        w_cal_cnt_nxt = r_cal_cnt + CAL_LOG2'(1);
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= RUN;
            r_cnt      <= '0;
            r_cal_cnt  <= '0;
            r_vld_pipe <= '0;
            r_cal_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cal_cnt  <= w_cal_cnt_nxt;
            r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_win_end};
            r_cal_done <= w_cal_end;
        end
    end

    assign result_valid = r_vld_pipe[STAGES];
    assign cal_busy     = (r_state == CAL);
    assign cal_done     = r_cal_done;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        gyro_chan_acc #(
            .IN_W        (IN_W),
            .ACC_W       (ACC_W),
            .OUT_W       (OUT_W),
            .SCALE_MUL   (SCALE_MUL),
            .SCALE_SHIFT (SCALE_SHIFT),
            .CAL_LOG2    (CAL_LOG2)
        ) u_ch (
            .clk       (clk_100mhz),
            .rst_n     (rst_in),
            .i_sample  (sample[k*IN_W +: IN_W]),
            .i_acc_en  (w_acc_en),
            .i_acc_clr (w_acc_clr),
            .i_win_end (w_win_end),
            .i_cal_en  (w_cal_en),
            .i_cal_clr (w_cal_clr),
            .i_cal_end (w_cal_end),
            .i_snap_ld (r_vld_pipe[0]),
            .i_res_ld  (r_vld_pipe[1]),
            .o_result  (result[k*OUT_W +: OUT_W]),
            .o_bias    (bias[k*IN_W +: IN_W])
        );
    end

endmodule

// File: tb/tb_gyro_integrator.sv
// Scoreboard bench: three gyro_integrator builds share one stimulus stream.
module tb_gyro_integrator;
    import gyro_pkg::*;

    localparam int N_CH     = 3;
    localparam int IN_W     = 16;
    localparam int WINDOW   = 4;
    localparam int CAL_LOG2 = 2;
    localparam int ND       = 3;

    typedef struct {
        int     due;
        longint sum[N_CH];
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sv = 1'b0;
    logic clr = 1'b0;
    logic cst = 1'b0;
    logic [N_CH*IN_W-1:0] smp = '0;

    logic [N_CH*32-1:0]   res_a;
    logic [N_CH*16-1:0]   res_b;
    logic [N_CH*32-1:0]   res_c;
    logic [ND-1:0]        rv, busy, done;
    logic [N_CH*IN_W-1:0] bias_w [ND];

    int n_chk = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    exp_t   sbq[$];
    int     calq[$];
    longint m_acc[N_CH], m_cal[N_CH], m_bias[N_CH];
    int     m_cnt, m_ccnt;
    bit     m_cal_st;
    longint hold[ND][N_CH];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    gyro_integrator #(.N_CH(N_CH), .IN_W(IN_W), .WINDOW(WINDOW), .ACC_W(40), .OUT_W(32),
                      .SCALE_MUL(1), .SCALE_SHIFT(2), .CAL_LOG2(CAL_LOG2)) u_dut_a (
        .clk_100mhz(clk), .rst_in(rst_n), .sample_valid(sv), .sample(smp), .clear(clr),
        .cal_start(cst), .result(res_a), .result_valid(rv[0]), .bias(bias_w[0]),
        .cal_busy(busy[0]), .cal_done(done[0]));

    gyro_integrator #(.N_CH(N_CH), .IN_W(IN_W), .WINDOW(WINDOW), .ACC_W(40), .OUT_W(16),
                      .SCALE_MUL(1), .SCALE_SHIFT(0), .CAL_LOG2(CAL_LOG2)) u_dut_b (
        .clk_100mhz(clk), .rst_in(rst_n), .sample_valid(sv), .sample(smp), .clear(clr),
        .cal_start(cst), .result(res_b), .result_valid(rv[1]), .bias(bias_w[1]),
        .cal_busy(busy[1]), .cal_done(done[1]));

    gyro_integrator #(.N_CH(N_CH), .IN_W(IN_W), .WINDOW(WINDOW), .ACC_W(40), .OUT_W(32),
                      .SCALE_MUL(7), .SCALE_SHIFT(3), .CAL_LOG2(CAL_LOG2)) u_dut_c (
        .clk_100mhz(clk), .rst_in(rst_n), .sample_valid(sv), .sample(smp), .clear(clr),
        .cal_start(cst), .result(res_c), .result_valid(rv[2]), .bias(bias_w[2]),
        .cal_busy(busy[2]), .cal_done(done[2]));

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v, input int ow);
        longint hi;
        hi = (64'sd1 <<< (ow - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    // Expected window result for each build: (sum*mul)>>>shift, clamped to its output width.
    function automatic longint exp_res(input int d, input longint sum);
        case (d)
            0:       return clamp(sum >>> 2, 32);
            1:       return clamp(sum, 16);
            default: return clamp((sum * 7) >>> 3, 32);
        endcase
    endfunction

    function automatic longint sx16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return longint'(t);
    endfunction

    function automatic longint get_res(input int d, input int k);
        case (d)
            0:       return longint'($signed(res_a[k*32 +: 32]));
            1:       return longint'($signed(res_b[k*16 +: 16]));
            default: return longint'($signed(res_c[k*32 +: 32]));
        endcase
    endfunction

    function automatic longint get_bias(input int d, input int k);
        logic [N_CH*IN_W-1:0] b;
        b = bias_w[d];
        return longint'($signed(b[k*IN_W +: IN_W]));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_acc[k] = 0; m_cal[k] = 0; m_bias[k] = 0;
            for (int d = 0; d < ND; d++) hold[d][k] = 0;
        end
        m_cnt = 0; m_ccnt = 0; m_cal_st = 1'b0;
        sbq.delete();
        calq.delete();
    endtask

    task automatic zero_run();
        for (int k = 0; k < N_CH; k++) begin
            m_acc[k] = 0; m_cal[k] = 0;
        end
        m_cnt = 0; m_ccnt = 0;
    endtask

    task automatic model_step(input bit v, input longint s[N_CH], input bit c, input bit cs);
        exp_t e;
        if (cs) begin
            m_cal_st = 1'b1; zero_run();
        end else if (c) begin
            m_cal_st = 1'b0; zero_run();
        end else if (v && !m_cal_st) begin
            for (int k = 0; k < N_CH; k++) m_acc[k] += s[k] - m_bias[k];
            if (m_cnt == WINDOW - 1) begin
                e.due = edge_cnt + 2;
                for (int k = 0; k < N_CH; k++) e.sum[k] = m_acc[k];
                sbq.push_back(e);
                zero_run();
            end else begin
                m_cnt++;
            end
        end else if (v) begin
            for (int k = 0; k < N_CH; k++) m_cal[k] += s[k];
            if (m_ccnt == (1 << CAL_LOG2) - 1) begin
                for (int k = 0; k < N_CH; k++) m_bias[k] = sx16(m_cal[k] >>> CAL_LOG2);
                calq.push_back(edge_cnt);
                m_cal_st = 1'b0;
                zero_run();
            end else begin
                m_ccnt++;
            end
        end
    endtask

    // Drive one cycle of stimulus, then advance the model past the same clock edge.
    task automatic cyc(input bit v, input longint s0, input longint s1, input longint s2,
                       input bit c, input bit cs);
        longint s[N_CH];
        s = '{s0, s1, s2};
        sv = v; clr = c; cst = cs;
        smp = {16'(s2), 16'(s1), 16'(s0)};
        @(posedge clk);
        #1;
        if (rst_n) model_step(v, s, c, cs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic rnd_cyc(input bit allow_ctl);
        longint a, b, c;
        a = longint'($urandom_range(0, 65535)) - 32768;
        b = longint'($urandom_range(0, 65535)) - 32768;
        c = longint'($urandom_range(0, 65535)) - 32768;
        cyc(($urandom % 4) != 0, a, b, c,
            allow_ctl && ($urandom % 20 == 0), allow_ctl && ($urandom % 30 == 0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rv"}, longint'(rv), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_res_a"}, longint'(res_a == '0), 1);
        check({tag, "_res_b"}, longint'(res_b == '0), 1);
        check({tag, "_res_c"}, longint'(res_c == '0), 1);
        for (int d = 0; d < ND; d++)
            check($sformatf("%s_bias%0d", tag, d), longint'(bias_w[d] == '0), 1);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sbq.size() > 0 && sbq[0].due == edge_cnt) begin
            e = sbq.pop_front();
            for (int d = 0; d < ND; d++) begin
                check($sformatf("rv%0d", d), longint'(rv[d]), 1);
                for (int k = 0; k < N_CH; k++) hold[d][k] = exp_res(d, e.sum[k]);
            end
        end else begin
            for (int d = 0; d < ND; d++)
                if (rv[d]) check($sformatf("rv_unexp%0d", d), 1, 0);
        end
        if (calq.size() > 0 && calq[0] == edge_cnt) begin
            void'(calq.pop_front());
            for (int d = 0; d < ND; d++) check($sformatf("cal_done%0d", d), longint'(done[d]), 1);
        end else begin
            for (int d = 0; d < ND; d++)
                if (done[d]) check($sformatf("cal_done_unexp%0d", d), 1, 0);
        end
        for (int d = 0; d < ND; d++) begin
            check($sformatf("busy%0d", d), longint'(busy[d]), longint'(m_cal_st));
            for (int k = 0; k < N_CH; k++) begin
                check($sformatf("res%0d_ch%0d", d, k), get_res(d, k), hold[d][k]);
                check($sformatf("bias%0d_ch%0d", d, k), get_bias(d, k), m_bias[k]);
            end
        end
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all_zero("rst0");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // back-to-back window
        repeat (WINDOW) cyc(1'b1, 100, -8, 0, 1'b0, 1'b0);
        idle(4);
        check("win1_x", get_res(0, CH_X), 100);
        check("win1_y", get_res(0, CH_Y), -8);

        // same window with idle gaps, then an independent window
        for (int i = 0; i < WINDOW; i++) begin
            cyc(1'b1, 100, -8, 0, 1'b0, 1'b0);
            idle($urandom_range(0, 3));
        end
        idle(3);
        repeat (WINDOW) cyc(1'b1, 4, 4, 4, 1'b0, 1'b0);
        idle(4);
        check("win3_z", get_res(0, CH_Z), 4);

        // calibration then bias-corrected window
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
        check("cal_busy_on", longint'(busy[0]), 1);
        repeat (1 << CAL_LOG2) cyc(1'b1, 10, -6, 3, 1'b0, 1'b0);
        check("cal_busy_off", longint'(busy[0]), 0);
        check("cal_bias_x", get_bias(0, CH_X), 10);
        idle(2);
        repeat (WINDOW) cyc(1'b1, 110, -6, 3, 1'b0, 1'b0);
        idle(4);
        check("biased_x", get_res(0, CH_X), 100);

        // recalibrate to zero bias, then saturation at both rails
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
        repeat (1 << CAL_LOG2) cyc(1'b1, 0, 0, 0, 1'b0, 1'b0);
        repeat (WINDOW) cyc(1'b1, 32767, -32768, 32767, 1'b0, 1'b0);
        idle(4);
        check("sat_hi_b", get_res(1, CH_X), 32767);
        repeat (WINDOW) cyc(1'b1, -32768, 32767, -32768, 1'b0, 1'b0);
        idle(4);
        check("sat_lo_b", get_res(1, CH_X), -32768);

        // clear drops the partial window and the same-cycle sample
        repeat (2) cyc(1'b1, 9, 9, 9, 1'b0, 1'b0);
        cyc(1'b1, 50, 50, 50, 1'b1, 1'b0);
        repeat (WINDOW) cyc(1'b1, 5, 5, 5, 1'b0, 1'b0);
        idle(4);
        check("clr_x", get_res(0, CH_X), 5);

        // cal_start beats clear; clear alone then aborts calibration
        cyc(1'b1, 77, 77, 77, 1'b1, 1'b1);
        check("cs_clr_busy", longint'(busy[0]), 1);
        repeat (2) cyc(1'b1, 200, 200, 200, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        check("abort_busy", longint'(busy[0]), 0);
        check("abort_bias", get_bias(0, CH_X), 0);

        // in-flight results survive clear and cal_start
        repeat (WINDOW) cyc(1'b1, -40, 12, 1000, 1'b0, 1'b0);
        cyc(1'b1, 1, 1, 1, 1'b1, 1'b0);
        idle(3);
        repeat (WINDOW) cyc(1'b1, 8, -12, 16, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
        repeat (1 << CAL_LOG2) cyc(1'b1, -3, 7, 1, 1'b0, 1'b0);
        idle(3);

        // random traffic with occasional control pulses
        for (int i = 0; i < 300; i++) rnd_cyc(1'b1);
        idle(4);

        // asynchronous reset in the middle of traffic
        for (int i = 0; i < 7; i++) rnd_cyc(1'b0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        model_reset();
        for (int i = 0; i < 3; i++) rnd_cyc(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) rnd_cyc(1'b0);
        idle(6);

        check("sb_empty", longint'(sbq.size()), 0);
        check("calq_empty", longint'(calq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gyro_integrator.md
Name: gyro_integrator

Overview:
- Parametrised multi-channel gyro rate integrator/averager. Sits between the IMU sample interface and the orientation/view-vector logic.
- Accumulates bias-corrected signed rate samples over a window of WINDOW accepted samples, then emits one scaled, saturated result per channel with a valid pulse.
- Adds three capabilities: valid-qualified input, runtime bias calibration, and output saturation.

Parameters:
- N_CH, 3, channel count; channel 0 = x/roll, 1 = y/pitch, 2 = z/yaw.
- IN_W, 16, signed sample width.
- WINDOW, 10000, accepted samples per output window; must be ≥ 2.
- ACC_W, 40, signed accumulator width; elaboration assert ACC_W ≥ IN_W+2+$clog2(WINDOW).
- OUT_W, 32, signed output width.
- SCALE_MUL, 7, unsigned scale multiplier.
- SCALE_SHIFT, 8, arithmetic right shift applied after the multiply.
- CAL_LOG2, 10, log2 of the calibration sample count.

Ports:
- clk_100mhz  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- sample_valid  in  1  samples are accepted on a cycle where this is high
- sample  in  N_CH*IN_W  packed signed samples; channel k at [k*IN_W +: IN_W]
- clear  in  1  pulse; discard the current window, keep the bias
- cal_start  in  1  pulse; begin bias calibration
- result  out  N_CH*OUT_W  packed signed scaled window results
- result_valid  out  1  one-cycle pulse marking new results
- bias  out  N_CH*IN_W  current per-channel bias
- cal_busy  out  1  high while in CAL
- cal_done  out  1  one-cycle pulse when the bias is updated

Behaviour:
- Reset (rst_in low, asynchronous): state=RUN; accumulators, counters, result, bias, result_valid, cal_busy and cal_done all 0. Flops clear immediately, not on the next clock edge.
- States: RUN, CAL.
  - RUN→CAL on cal_start.
  - CAL→RUN after 2^CAL_LOG2 accepted samples.
- RUN, on an accepted sample: acc[k] += sext(sample[k]) − sext(bias[k]), computed at IN_W+1 bits; cnt += 1.
- Window end:
  - When cnt==WINDOW−1 and a sample is accepted, the final total (including that sample) goes to snap[k].
  - The accumulators restart at 0 with no dropped sample; cnt restarts at 0.
- Output pipeline:
  - Stage 1: snap is registered.
  - Stage 2: result[k] = sat_OUT_W((snap[k]*SCALE_MUL) >>> SCALE_SHIFT), product width ACC_W+32, arithmetic shift. result_valid pulses in this cycle.
  - Latency: result_valid is high exactly 2 cycles after the clock edge that accepted the WINDOW-th sample.
  - result holds its value until the next window.
- Saturation: clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- CAL:
  - cal_busy=1 throughout; no window counting and no result_valid.
  - cal_acc[k] += raw sample; after 2^CAL_LOG2 samples, bias[k] = cal_acc[k] >>> CAL_LOG2, truncated to IN_W bits.
  - cal_done pulses on the cycle bias updates. Return to RUN with acc and cnt at 0.
- clear: zeros acc, cnt and cal_acc. A sample presented in the same cycle is dropped.
  - In CAL, clear aborts calibration back to RUN; bias is unchanged and no cal_done pulse.
- cal_start: in RUN it discards the partial window. In CAL it restarts calibration from 0. A sample in the same cycle is dropped.
- Simultaneous cal_start and clear: cal_start wins.
- An in-flight pipeline result still emits its result_valid after clear or cal_start.
- sample_valid gaps: no effect other than delay.

Decomposition:
- Package gyro_pkg:
  - typedef enum {RUN, CAL} gyro_state_t
  - sat function (signed, parametrised widths)
  - default constants for channel indices
- Sub-module gyro_chan_acc: one per channel via generate.
  - Contains the accumulator, calibration accumulator, bias register, snapshot and scale/saturate stage.
  - Driven by shared strobes from the top-level FSM/counter (acc_en, acc_clr, win_end, cal_en, cal_end).

Test Plan:
- Reset: hold rst_in low mid-stream with random sample_valid → all outputs 0 asynchronously; after release, first result_valid only after WINDOW accepted samples.
- WINDOW=4, SCALE_MUL=1, SCALE_SHIFT=2, samples (100,−8,0) for 4 consecutive cycles → result_valid 2 cycles after the 4th; result=(100,−8,0); exactly one pulse.
- Same config, the 4 samples separated by 0–3 idle cycles each → same result; no early pulse; each window independent (next window of (4,4,4) → result=(4,4,4)).
- CAL_LOG2=2: cal_start, 4 samples x=10 → cal_done, bias_x=10, cal_busy low. Then 4 samples x=110 → result_x=100.
- OUT_W=16, SCALE_MUL=1, SCALE_SHIFT=0, 4 samples of 32767 → result=32767 (saturated). 4 samples of −32768 → result=−32768.
- 2 samples of 9, then clear together with a sample of 50, then 4 samples of 5 → result=5 (mul=1, shift=2). cal_start and clear in the same cycle → cal_busy=1.
